// File: rtl/voting_machine_n.sv
// ---------------------------------------------------------------------------
// voting_machine_n
//
// N-candidate electronic voting tally. One vote is counted per button release
// (1->0 edge). Each accepted vote starts a lockout window of HOLD_CYCLES
// cycles. A cycle with more than one release is discarded and flagged. When
// voting closes, every candidate's count is snapshotted to o_count and a
// sequential scan (one candidate per cycle) finds the winner and tie flag.
//
// Parameters
//   NUM_CAND    : number of candidates (2..16)
//   CNT_W       : width of each vote counter (saturating)
//   HOLD_CYCLES : lockout length after an accepted vote (>= 1)
//   IDX_W       : candidate index width, derived from NUM_CAND
//
// Ports
//   clk           : system clock, rising edge
//   rst           : asynchronous active-high reset
//   i_candidate   : vote buttons, one bit per candidate
//   i_voting_over : high closes voting and publishes results
//   o_count       : snapshot counts, candidate k at [k*CNT_W +: CNT_W]
//   o_winner      : index of highest count, lowest index on a tie
//   o_tie         : two or more candidates share the maximum
//   o_valid       : o_winner/o_tie valid for the current snapshot
//   o_hold        : high while in the lockout window
//   o_reject      : one-cycle pulse when a multi-release is discarded
//
// Handshake: o_valid is a level qualifier, not a pulse. It rises once the
// scan finishes and stays high while i_voting_over stays high; o_winner and
// o_tie are only meaningful while o_valid is high. There is no ready input:
// the consumer samples whenever o_valid is high.
// ---------------------------------------------------------------------------
module voting_machine_n #(
  parameter int NUM_CAND    = 4,
  parameter int CNT_W       = 16,
  parameter int HOLD_CYCLES = 16,
  parameter int IDX_W       = $clog2(NUM_CAND)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_CAND-1:0]       i_candidate,
  input  logic                      i_voting_over,
  output logic [NUM_CAND*CNT_W-1:0] o_count,
  output logic [IDX_W-1:0]          o_winner,
  output logic                      o_tie,
  output logic                      o_valid,
  output logic                      o_hold,
  output logic                      o_reject
);

  // The hold counter runs 0..HOLD_CYCLES-1.
  localparam int HC_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CAND - 1);
  localparam logic [HC_W-1:0]  HOLD_LAST = HC_W'(HOLD_CYCLES - 1);

  // State is kept in state_q with fixed encodings so it can be probed
  // directly by checkers.
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_VOTE   = 2'd1,
    S_HOLD   = 2'd2,
    S_FINISH = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [HC_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic [NUM_CAND-1:0] prev_q, prev_d;
  logic [CNT_W-1:0]  cnt_q  [NUM_CAND];
  logic [CNT_W-1:0]  cnt_d  [NUM_CAND];
  logic [CNT_W-1:0]  snap_q [NUM_CAND];
  logic [CNT_W-1:0]  snap_d [NUM_CAND];
  logic [IDX_W-1:0]  scan_idx_q, scan_idx_d;
  logic [CNT_W-1:0]  max_q, max_d;
  logic [IDX_W-1:0]  best_q, best_d;
  logic              run_tie_q, run_tie_d;
  logic              scan_busy_q, scan_busy_d;
  logic [IDX_W-1:0]  winner_q, winner_d;
  logic              tie_q, tie_d;
  logic              valid_q, valid_d;
  logic              reject_q, reject_d;

  // Release decode
  logic [NUM_CAND-1:0] release_vec;
  logic                rel_one;
  logic                rel_multi;
  logic [IDX_W-1:0]    rel_idx;
  logic [CNT_W-1:0]    cur_cnt;
  logic                enter_finish;

  assign release_vec = prev_q & ~i_candidate;
  assign rel_one     = $onehot(release_vec);
  assign rel_multi   = (release_vec != '0) && !rel_one;
  assign cur_cnt     = snap_q[scan_idx_q];

  always_comb begin
    rel_idx = '0;
    for (int k = 0; k < NUM_CAND; k++) begin
      if (release_vec[k]) rel_idx = IDX_W'(k);
    end
  end

  // prev tracks the buttons in every state, so a release that happens during
  // IDLE/HOLD/FINISH is consumed there and never counted later.
  assign prev_d = i_candidate;

  always_comb begin
    state_d      = state_q;
    hold_cnt_d   = hold_cnt_q;
    cnt_d        = cnt_q;
    snap_d       = snap_q;
    scan_idx_d   = scan_idx_q;
    max_d        = max_q;
    best_d       = best_q;
    run_tie_d    = run_tie_q;
    scan_busy_d  = scan_busy_q;
    winner_d     = winner_q;
    tie_d        = tie_q;
    valid_d      = valid_q;
    reject_d     = 1'b0;
    enter_finish = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        state_d = S_VOTE;
      end

      S_VOTE: begin
        // Closing voting wins over any release in the same cycle.
        if (i_voting_over) begin
          enter_finish = 1'b1;
        end else if (rel_one) begin
          if (cnt_q[rel_idx] != CNT_MAX) begin
            cnt_d[rel_idx] = cnt_q[rel_idx] + CNT_W'(1);
          end
          hold_cnt_d = '0;
          state_d    = S_HOLD;
        end else if (rel_multi) begin
          reject_d = 1'b1;
        end
      end

      S_HOLD: begin
        if (i_voting_over) begin
          enter_finish = 1'b1;
        end else if (hold_cnt_q == HOLD_LAST) begin
          state_d = S_VOTE;
        end else begin
          hold_cnt_d = hold_cnt_q + HC_W'(1);
        end
      end

      S_FINISH: begin
        if (!i_voting_over) begin
          // Leaving FINISH aborts any scan in flight; published counts and
          // last winner/tie stay put, only the qualifier drops.
          state_d     = S_IDLE;
          valid_d     = 1'b0;
          scan_busy_d = 1'b0;
        end else if (scan_busy_q) begin
          // Running max starts at zero with no tie, so candidate 0 with a
          // zero count registers as a tie; all-zero tallies end as winner 0
          // with tie set.
          if (cur_cnt > max_q) begin
            max_d     = cur_cnt;
            best_d    = scan_idx_q;
            run_tie_d = 1'b0;
          end else if (cur_cnt == max_q) begin
            run_tie_d = 1'b1;
          end
          if (scan_idx_q == LAST_IDX) begin
            winner_d    = best_d;
            tie_d       = run_tie_d;
            valid_d     = 1'b1;
            scan_busy_d = 1'b0;
          end else begin
            scan_idx_d = scan_idx_q + IDX_W'(1);
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (enter_finish) begin
      state_d     = S_FINISH;
      snap_d      = cnt_q;
      valid_d     = 1'b0;
      scan_busy_d = 1'b1;
      scan_idx_d  = '0;
      max_d       = '0;
      best_d      = '0;
      run_tie_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      hold_cnt_q  <= '0;
      prev_q      <= '0;
      scan_idx_q  <= '0;
      max_q       <= '0;
      best_q      <= '0;
      run_tie_q   <= 1'b0;
      scan_busy_q <= 1'b0;
      winner_q    <= '0;
      tie_q       <= 1'b0;
      valid_q     <= 1'b0;
      reject_q    <= 1'b0;
      for (int k = 0; k < NUM_CAND; k++) begin
        cnt_q[k]  <= '0;
        snap_q[k] <= '0;
      end
    end else begin
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      prev_q      <= prev_d;
      scan_idx_q  <= scan_idx_d;
      max_q       <= max_d;
      best_q      <= best_d;
      run_tie_q   <= run_tie_d;
      scan_busy_q <= scan_busy_d;
      winner_q    <= winner_d;
      tie_q       <= tie_d;
      valid_q     <= valid_d;
      reject_q    <= reject_d;
      for (int k = 0; k < NUM_CAND; k++) begin
        cnt_q[k]  <= cnt_d[k];
        snap_q[k] <= snap_d[k];
      end
    end
  end

  always_comb begin
    o_count = '0;
    for (int k = 0; k < NUM_CAND; k++) begin
      o_count[k*CNT_W +: CNT_W] = snap_q[k];
    end
  end

  assign o_winner = winner_q;
  assign o_tie    = tie_q;
  assign o_valid  = valid_q;
  assign o_hold   = (state_q == S_HOLD);
  assign o_reject = reject_q;

endmodule

// File: tb/tb_voting_machine_n.sv
// ---------------------------------------------------------------------------
// tb_voting_machine_n
//
// Bench for voting_machine_n with NUM_CAND=4, CNT_W=2, HOLD_CYCLES=4.
// Drivers push the hand-computed result word {counts, winner, tie} into
// exp_q when voting closes; a monitor pops and compares on every o_valid
// rising edge. Inputs change 1 time unit after a rising edge; the monitor
// samples on the falling edge.
// ---------------------------------------------------------------------------
module tb_voting_machine_n;

  localparam int NC = 4;
  localparam int CW = 2;
  localparam int HC = 4;
  localparam int IW = 2;
  localparam int W  = NC*CW + IW + 1;

  logic             clk = 1'b0;
  logic             rst;
  logic [NC-1:0]    cand;
  logic             vo;
  logic [NC*CW-1:0] o_count;
  logic [IW-1:0]    o_winner;
  logic             o_tie;
  logic             o_valid;
  logic             o_hold;
  logic             o_reject;

  int tests_run    = 0;
  int tests_failed = 0;
  logic [W-1:0] exp_q[$];

  voting_machine_n #(
    .NUM_CAND    (NC),
    .CNT_W       (CW),
    .HOLD_CYCLES (HC)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .i_candidate   (cand),
    .i_voting_over (vo),
    .o_count       (o_count),
    .o_winner      (o_winner),
    .o_tie         (o_tie),
    .o_valid       (o_valid),
    .o_hold        (o_hold),
    .o_reject      (o_reject)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst  = 1'b1;
    cand = '0;
    vo   = 1'b0;
    tick(2);
    rst = 1'b0;
    tick(2);
  endtask

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] pack(input int c0, input int c1,
                                        input int c2, input int c3,
                                        input int win, input int tie);
    return {CW'(c3), CW'(c2), CW'(c1), CW'(c0), IW'(win), 1'(tie)};
  endfunction

  // Drivers
  task automatic press_release(input int k);
    cand[k] = 1'b1;
    tick(1);
    cand[k] = 1'b0;
    tick(1);
  endtask

  task automatic vote(input int k);
    press_release(k);
    tick(6);
  endtask

  task automatic close_voting(input logic [W-1:0] exp_word);
    logic [NC*CW-1:0] exp_counts;
    int lat;
    exp_counts = exp_word[W-1:IW+1];
    exp_q.push_back(exp_word);
    vo = 1'b1;
    tick(1);
    check("finish_entry_state", 32'(dut.state_q), 32'd3);
    check("count_snapshot", 32'(o_count), 32'(exp_counts));
    lat = 0;
    while (!o_valid && lat < 20) begin
      tick(1);
      lat++;
    end
    check("valid_latency", 32'(lat), 32'(NC));
    vo = 1'b0;
    tick(1);
    check("valid_cleared", 32'(o_valid), 32'd0);
    check("idle_after_close", 32'(dut.state_q), 32'd0);
    check("count_held", 32'(o_count), 32'(exp_counts));
  endtask

  // Scoreboard monitor
  initial begin
    logic vp;
    logic [W-1:0] e;
    vp = 1'b0;
    forever begin
      @(negedge clk);
      if (o_valid && !vp) begin
        if (exp_q.size() == 0) begin
          tests_run++;
          tests_failed++;
          $display("FAIL unexpected_result: got 0x%0h, expected none",
                   {o_count, o_winner, o_tie});
        end else begin
          e = exp_q.pop_front();
          check("result", 32'({o_count, o_winner, o_tie}), 32'(e));
        end
      end
      vp = o_valid;
    end
  end

  // Stimulus
  initial begin
    rst  = 1'b1;
    cand = '0;
    vo   = 1'b0;
    tick(2);
    check("reset_count", 32'(o_count), 32'd0);
    check("reset_flags", 32'({o_winner, o_tie, o_valid, o_hold, o_reject}), 32'd0);
    rst = 1'b0;
    tick(1);
    check("idle_to_vote", 32'(dut.state_q), 32'd1);
    tick(1);

    // Single votes: c0, c2, c2
    press_release(0);
    check("vote_enters_hold", 32'(dut.state_q), 32'd2);
    check("hold_flag", 32'(o_hold), 32'd1);
    tick(6);
    vote(2);
    vote(2);
    close_voting(pack(1, 0, 2, 0, 2, 0));

    // Lockout: c1 release at edge t, c3 at t+2, c2 at t+4 (all lockout),
    // c0 at t+5 (first cycle back in VOTE).
    apply_reset();
    cand[1] = 1'b1;
    cand[3] = 1'b1;
    tick(1);
    cand[1] = 1'b0;
    tick(1);
    check("lock_hold_t0", 32'(o_hold), 32'd1);
    tick(1);
    check("lock_hold_t1", 32'(o_hold), 32'd1);
    cand[3] = 1'b0;
    tick(1);
    check("lock_hold_t2", 32'(o_hold), 32'd1);
    cand[2] = 1'b1;
    tick(1);
    check("lock_hold_t3", 32'(o_hold), 32'd1);
    cand[2] = 1'b0;
    cand[0] = 1'b1;
    tick(1);
    check("lock_hold_t4", 32'(o_hold), 32'd0);
    check("lock_vote_t4", 32'(dut.state_q), 32'd1);
    cand[0] = 1'b0;
    tick(1);
    check("lock_reaccept_t5", 32'(o_hold), 32'd1);
    tick(6);
    close_voting(pack(1, 1, 0, 0, 0, 1));

    // Simultaneous release
    apply_reset();
    cand[0] = 1'b1;
    cand[1] = 1'b1;
    tick(1);
    cand = '0;
    tick(1);
    check("reject_pulse", 32'(o_reject), 32'd1);
    check("reject_stays_vote", 32'(dut.state_q), 32'd1);
    tick(1);
    check("reject_one_cycle", 32'(o_reject), 32'd0);
    close_voting(pack(0, 0, 0, 0, 0, 1));

    // Tie, then resume
    apply_reset();
    vote(1);
    vote(1);
    vote(3);
    vote(3);
    close_voting(pack(0, 2, 0, 2, 1, 1));
    tick(1);
    check("resume_vote", 32'(dut.state_q), 32'd1);
    vote(3);
    close_voting(pack(0, 2, 0, 3, 3, 0));

    // Saturation at 2^CNT_W-1
    apply_reset();
    for (int i = 0; i < 5; i++) vote(0);
    close_voting(pack(3, 0, 0, 0, 0, 0));

    // Async reset mid-scan
    apply_reset();
    vote(1);
    vote(1);
    vo = 1'b1;
    tick(2);
    #2 rst = 1'b1;
    #1;
    check("rst_scan_count", 32'(o_count), 32'd0);
    check("rst_scan_flags", 32'({o_winner, o_tie, o_valid, o_hold, o_reject}), 32'd0);
    check("rst_scan_state", 32'(dut.state_q), 32'd0);
    vo = 1'b0;
    tick(1);
    rst = 1'b0;
    tick(2);

    // Async reset mid-HOLD
    press_release(2);
    tick(1);
    #2 rst = 1'b1;
    #1;
    check("rst_hold_flag", 32'(o_hold), 32'd0);
    check("rst_hold_state", 32'(dut.state_q), 32'd0);
    tick(1);
    rst = 1'b0;
    vote(1);
    close_voting(pack(0, 1, 0, 0, 1, 0));

    tick(2);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
